// File: rtl/vga_board_scanner.sv
// 640x480@60 raster generator with board-region decode for the drawing mux.
// Counters advance on the pixel tick; decoded outputs are registered one pixel behind.
`timescale 1ns/1ps

module vga_board_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int GRID     = 7,
    parameter int CELL_SZ  = 64,
    parameter int BOARD_X0 = 96,
    parameter int BOARD_Y0 = 16,
    parameter int LINE_W   = 2,
    parameter int DIV_X    = 576,
    parameter int DIV_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   vga_clk,
    output logic                   pix_tick,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   blank_n,
    output logic [9:0]             x,
    output logic [9:0]             y,
    output logic                   line,
    output logic [GRID*GRID-1:0]   cell_hit,
    output logic                   division,
    output logic                   frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BSZ   = GRID * CELL_SZ;
    localparam int CSH   = $clog2(CELL_SZ);
    localparam int CW    = $clog2(GRID);
    localparam int NC    = GRID * GRID;
    localparam int IW    = $clog2(NC);

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BX0    = 10'(BOARD_X0);
    localparam logic [9:0] BY0    = 10'(BOARD_Y0);
    localparam logic [9:0] BX1    = 10'(BOARD_X0 + BSZ);
    localparam logic [9:0] BY1    = 10'(BOARD_Y0 + BSZ);
    localparam logic [9:0] EDGE   = 10'(BSZ - LINE_W);
    localparam logic [9:0] DX0    = 10'(DIV_X);
    localparam logic [9:0] DX1    = 10'(DIV_X + DIV_W);
    localparam logic [CSH-1:0] LW_C = CSH'(LINE_W);

    logic           rst_meta;
    logic           rst_sync;
    logic           tog;
    logic [9:0]     h;
    logic [9:0]     v;

    logic           active;
    logic           in_board;
    logic           grid_d;
    logic           div_d;
    logic           hs_d;
    logic           vs_d;
    logic [9:0]     rx;
    logic [9:0]     ry;
    logic [CW-1:0]  col;
    logic [CW-1:0]  row;
    logic [IW-1:0]  idx;
    logic [NC-1:0]  cell_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Pixel tick and raster counters; held in reset until the synchronised release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog      <= 1'b0;
            pix_tick <= 1'b0;
            h        <= '0;
            v        <= '0;
        end else if (!rst_sync) begin
            tog      <= 1'b0;
            pix_tick <= 1'b0;
            h        <= '0;
            v        <= '0;
        end else begin
            tog      <= ~tog;
            pix_tick <= tog;
            if (pix_tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    assign vga_clk = tog;

    // Cell size is a power of two, so row/col and the in-cell offset are plain bit slices.
    always_comb begin
        active   = (h < H_ACT) && (v < V_ACT);
        rx       = h - BX0;
        ry       = v - BY0;
        in_board = active && (h >= BX0) && (h < BX1) && (v >= BY0) && (v < BY1);
        col      = CW'(rx >> CSH);
        row      = CW'(ry >> CSH);
        idx      = IW'(row) * IW'(GRID) + IW'(col);
        grid_d   = in_board && ((rx[CSH-1:0] < LW_C) || (ry[CSH-1:0] < LW_C) ||
                                (rx >= EDGE) || (ry >= EDGE));
        cell_d   = '0;
        if (in_board && !grid_d) begin
            cell_d[idx] = 1'b1;
        end
        div_d    = active && !in_board && (h >= DX0) && (h < DX1);
        hs_d     = !((h >= HS_BEG) && (h < HS_END));
        vs_d     = !((v >= VS_BEG) && (v < VS_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank_n     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line        <= 1'b0;
            cell_hit    <= '0;
            division    <= 1'b0;
            frame_start <= 1'b0;
        end else if (!rst_sync) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank_n     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line        <= 1'b0;
            cell_hit    <= '0;
            division    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                hsync_n     <= hs_d;
                vsync_n     <= vs_d;
                blank_n     <= active;
                x           <= h;
                y           <= v;
                line        <= grid_d;
                cell_hit    <= cell_d;
                division    <= div_d;
                frame_start <= (h == '0) && (v == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_board_scanner.sv
// Scoreboard bench: a full-size scanner plus a shrunken-geometry one whose whole frame fits the run.
`timescale 1ns/1ps

module tb_vga_board_scanner;
    localparam int NC = 49;

    typedef struct packed {
        int ha, hf, hsw, hb, va, vf, vsw, vb, bx, by, csz, gr, lw, dx, dw;
    } geom_t;

    typedef struct packed {
        logic hs, vs, bl;
        logic [9:0] x, y;
        logic ln, dv;
        logic [NC-1:0] ch;
        logic fs;
    } exp_t;

    localparam geom_t GA = '{640, 16, 96, 48, 480, 10, 2, 33, 96, 16, 64, 7, 2, 576, 8};
    localparam geom_t GB = '{100, 4, 8, 8, 70, 2, 2, 2, 8, 4, 8, 7, 2, 72, 4};

    logic clk;
    logic rst_n;

    logic vga_clk_a, pix_tick_a, hsync_n_a, vsync_n_a, blank_n_a, line_a, division_a, frame_start_a;
    logic [9:0] x_a, y_a;
    logic [NC-1:0] cell_hit_a;
    logic vga_clk_b, pix_tick_b, hsync_n_b, vsync_n_b, blank_n_b, line_b, division_b, frame_start_b;
    logic [9:0] x_b, y_b;
    logic [NC-1:0] cell_hit_b;

    int n_cmp = 0;
    int n_bad = 0;

    vga_board_scanner dut_a (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk_a), .pix_tick(pix_tick_a),
        .hsync_n(hsync_n_a), .vsync_n(vsync_n_a), .blank_n(blank_n_a), .x(x_a), .y(y_a),
        .line(line_a), .cell_hit(cell_hit_a), .division(division_a), .frame_start(frame_start_a)
    );

    vga_board_scanner #(
        .H_ACTIVE(100), .H_FP(4), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(70), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .GRID(7), .CELL_SZ(8), .BOARD_X0(8), .BOARD_Y0(4), .LINE_W(2), .DIV_X(72), .DIV_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk_b), .pix_tick(pix_tick_b),
        .hsync_n(hsync_n_b), .vsync_n(vsync_n_b), .blank_n(blank_n_b), .x(x_b), .y(y_b),
        .line(line_b), .cell_hit(cell_hit_b), .division(division_b), .frame_start(frame_start_b)
    );

    exp_t oa, ob;
    assign oa = {hsync_n_a, vsync_n_a, blank_n_a, x_a, y_a, line_a, division_a, cell_hit_a, frame_start_a};
    assign ob = {hsync_n_b, vsync_n_b, blank_n_b, x_b, y_b, line_b, division_b, cell_hit_b, frame_start_b};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int h, input int v, input geom_t g);
        exp_t e;
        int rx, ry, bsz;
        logic act, inb;
        e     = '0;
        act   = (h < g.ha) && (v < g.va);
        e.hs  = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hsw));
        e.vs  = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vsw));
        e.bl  = act;
        e.x   = 10'(h);
        e.y   = 10'(v);
        rx    = h - g.bx;
        ry    = v - g.by;
        bsz   = g.gr * g.csz;
        inb   = act && (rx >= 0) && (ry >= 0) && (rx < bsz) && (ry < bsz);
        if (inb) begin
            e.ln = (rx % g.csz < g.lw) || (ry % g.csz < g.lw) || (rx >= bsz - g.lw) || (ry >= bsz - g.lw);
            if (!e.ln) e.ch[(ry / g.csz) * g.gr + rx / g.csz] = 1'b1;
        end
        e.dv  = act && !inb && (h >= g.dx) && (h < g.dx + g.dw);
        e.fs  = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic advance(inout int h, inout int v, input geom_t g);
        h++;
        if (h == g.ha + g.hf + g.hsw + g.hb) begin
            h = 0;
            v++;
            if (v == g.va + g.vf + g.vsw + g.vb) v = 0;
        end
    endtask

    task automatic sb_cmp(input string sfx, input exp_t o, input exp_t e);
        chk({"sync_", sfx},   64'({o.hs, o.vs, o.bl}), 64'({e.hs, e.vs, e.bl}));
        chk({"pos_", sfx},    64'({o.x, o.y}),         64'({e.x, e.y}));
        chk({"region_", sfx}, 64'({o.ln, o.dv, o.ch}), 64'({e.ln, e.dv, e.ch}));
        chk({"fstart_", sfx}, 64'(o.fs),               64'(e.fs));
    endtask

    task automatic sb_hold(input string sfx, input exp_t o, input exp_t l);
        chk({"hold_", sfx},      64'({o.hs, o.vs, o.bl, o.x, o.y, o.ln, o.dv, o.fs}),
                                 64'({l.hs, l.vs, l.bl, l.x, l.y, l.ln, l.dv, 1'b0}));
        chk({"hold_cell_", sfx}, 64'(o.ch), 64'(l.ch));
    endtask

    function automatic exp_t reset_obs();
        exp_t r;
        r    = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    // Instance A: full geometry, per-pixel compare plus per-line statistics.
    exp_t qa[$];
    exp_t ea, la;
    int   ha_m, va_m, a_ticks, a_hs, a_bl, a_line_y;
    bit   a_have;

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            ha_m = 0; va_m = 0; a_have = 0;
            a_ticks = 0; a_hs = 0; a_bl = 0;
            la = reset_obs();
        end else begin
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                sb_cmp("a", oa, ea);
                if (ea.x == 0) begin
                    if (a_have) begin
                        chk("line_ticks_a", 64'(a_ticks), 64'd800);
                        chk("hsync_ticks_a", 64'(a_hs), 64'd96);
                        chk("blank_ticks_a", 64'(a_bl), (a_line_y < 480) ? 64'd640 : 64'd0);
                    end
                    a_have = 1; a_ticks = 0; a_hs = 0; a_bl = 0; a_line_y = int'(ea.y);
                end
                a_ticks++;
                if (!oa.hs) a_hs++;
                if (oa.bl) a_bl++;
                if (ea.x == 298 && ea.y == 30) chk("spot_cell3_a", 64'({oa.ln, oa.dv, oa.ch}), 64'd1 << 3);
                if (ea.x == 160 && ea.y == 30) chk("spot_line_a",  64'({oa.ln, oa.dv, oa.ch}), 64'd1 << 50);
                if (ea.x == 96  && ea.y == 16) chk("spot_corner_a", 64'({oa.ln, oa.dv, oa.ch}), 64'd1 << 50);
                if (ea.x == 578 && ea.y == 30) chk("spot_div_a",   64'({oa.ln, oa.dv, oa.ch}), 64'd1 << 49);
                if (ea.x == 700 && ea.y == 30) chk("spot_blank_a", 64'({oa.bl, oa.ln, oa.dv, oa.ch}), 64'd0);
                la = oa;
            end
            if (pix_tick_a) begin
                chk("vga_clk_a", 64'(vga_clk_a), 64'd0);
                sb_hold("a", oa, la);
                qa.push_back(model(ha_m, va_m, GA));
                advance(ha_m, va_m, GA);
            end
        end
    end

    // Instance B: shrunken geometry, per-pixel compare plus per-frame statistics.
    exp_t qb[$];
    exp_t eb, lb;
    int   hb_m, vb_m, b_ticks, b_vs, b_fs;
    bit   b_have;

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
            hb_m = 0; vb_m = 0; b_have = 0;
            b_ticks = 0; b_vs = 0; b_fs = 0;
            lb = reset_obs();
        end else begin
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                sb_cmp("b", ob, eb);
                if (eb.fs) begin
                    if (b_have) begin
                        chk("frame_ticks_b", 64'(b_ticks), 64'd9120);
                        chk("vsync_ticks_b", 64'(b_vs), 64'd240);
                        chk("fstart_count_b", 64'(b_fs), 64'd1);
                    end
                    b_have = 1; b_ticks = 0; b_vs = 0; b_fs = 0;
                end
                b_ticks++;
                if (!ob.vs) b_vs++;
                if (ob.fs) b_fs++;
                if (eb.x == 36  && eb.y == 24) chk("spot_cell17_b", 64'({ob.ln, ob.dv, ob.ch}), 64'd1 << 17);
                if (eb.x == 16  && eb.y == 24) chk("spot_line_b",   64'({ob.ln, ob.dv, ob.ch}), 64'd1 << 50);
                if (eb.x == 73  && eb.y == 24) chk("spot_div_b",    64'({ob.ln, ob.dv, ob.ch}), 64'd1 << 49);
                if (eb.x == 110 && eb.y == 24) chk("spot_blank_b",  64'({ob.bl, ob.ln, ob.dv, ob.ch}), 64'd0);
                lb = ob;
            end
            if (pix_tick_b) begin
                chk("vga_clk_b", 64'(vga_clk_b), 64'd0);
                sb_hold("b", ob, lb);
                qb.push_back(model(hb_m, vb_m, GB));
                advance(hb_m, vb_m, GB);
            end
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ctl"}, 64'({vga_clk_a, pix_tick_a, hsync_n_a, vsync_n_a, blank_n_a,
                                line_a, division_a, frame_start_a, x_a, y_a}),
                           64'({8'b0011_0000, 10'd0, 10'd0}));
        chk({tag, "_cell"}, 64'(cell_hit_a), 64'd0);
    endtask

    task automatic wait_first_pixel(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = frame_start_a;
        end
        chk({tag, "_fstart_seen"}, 64'(seen), 64'd1);
        chk({tag, "_first_px"}, 64'({vsync_n_a, blank_n_a, x_a, y_a}), 64'({1'b1, 1'b1, 10'd0, 10'd0}));
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_a("rst_hold");
        rst_n = 1'b1;
        wait_first_pixel("power_up");

        hit = 0;
        for (int i = 0; i < 52000 && !hit; i++) begin
            @(negedge clk);
            hit = (y_a == 10'd31);
        end
        chk("reach_y31", 64'(hit), 64'd1);
        hit = 0;
        for (int i = 0; i < 1700 && !hit; i++) begin
            @(negedge clk);
            hit = (x_a == 10'd300);
        end
        chk("reach_x300", 64'(hit), 64'd1);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_a("rst_mid");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_first_pixel("restart");
        repeat (3300) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
